// File: rtl/neuron_feeder_if.sv
// rtl/neuron_feeder_if.sv - handshake/bus bundle between a feeder client and neuron_feeder
//
// Purpose: groups the buffer write port, the start/busy/done control, the
//          word stream to the neuron and the neuron result return path.
// Signals:
//   wr_en, wr_addr, wr_data      buffer write port (client -> feeder)
//   start                        begin-transaction request (client -> feeder)
//   busy, done, result           status and captured result (feeder -> client)
//   input_val, input_valid       word stream (feeder -> neuron)
//   neuron_out, neuron_out_valid neuron result (neuron -> feeder)
//   timeout                      abort pulse, only with FEEDER_TIMEOUT_EN
// Modports: master = client/neuron side, slave = neuron_feeder.
// Optional feature macro: FEEDER_TIMEOUT_EN
interface neuron_feeder_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAWIDTH  = 16
);
  localparam int ADDR_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATAWIDTH-1:0]  wr_data;
  logic                  start;
  logic                  busy;
  logic [DATAWIDTH-1:0]  input_val;
  logic                  input_valid;
  logic [DATAWIDTH-1:0]  neuron_out;
  logic                  neuron_out_valid;
  logic [DATAWIDTH-1:0]  result;
  logic                  done;
`ifdef FEEDER_TIMEOUT_EN
  logic                  timeout;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, start, neuron_out, neuron_out_valid,
    input  busy, input_val, input_valid, result, done
`ifdef FEEDER_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, neuron_out, neuron_out_valid,
    output busy, input_val, input_valid, result, done
`ifdef FEEDER_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/neuron_feeder.sv
// rtl/neuron_feeder.sv - streams a register buffer into a neuron and captures its result
//
// Purpose: holds NUM_INPUTS words written while idle; on start streams them
//          (buf[0] first, one per cycle) to the neuron, then waits for the
//          neuron result, registers it and pulses done.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - neuron_feeder_if.slave (write port, start/busy/done, stream, result)
// Optional feature macro: FEEDER_TIMEOUT_EN (WAIT-state timeout with a
//   one-cycle timeout pulse after TIMEOUT_CYCLES cycles).
module neuron_feeder #(
  parameter int NUM_INPUTS     = 4,
  parameter int DATAWIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  neuron_feeder_if.slave  bus
);
  localparam int ADDR_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATAWIDTH-1:0]  mem_q [NUM_INPUTS];
  logic [DATAWIDTH-1:0]  mem_d [NUM_INPUTS];
  logic [DATAWIDTH-1:0]  result_q, result_d;
  logic                  done_q, done_d;

`ifdef FEEDER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_d     = mem_q;
    result_d  = result_q;
    done_d    = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A write landing on the start edge is already in mem_q when word 0 is shown.
        if (bus.wr_en && (32'(bus.wr_addr) < 32'(NUM_INPUTS))) begin
          mem_d[bus.wr_addr] = bus.wr_data;
        end
        if (bus.start) begin
          state_d = S_SEND;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (idx_q == ADDR_WIDTH'(NUM_INPUTS - 1)) begin
          state_d   = S_WAIT;
          idx_d     = '0;
`ifdef FEEDER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      S_WAIT: begin
        if (bus.neuron_out_valid) begin
          result_d = bus.neuron_out;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) mem_q[i] <= '0;
`ifdef FEEDER_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      done_q   <= done_d;
      mem_q    <= mem_d;
`ifdef FEEDER_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Stream outputs decode straight from state so reset zeroes them at once.
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.input_valid = (state_q == S_SEND);
  assign bus.input_val   = (state_q == S_SEND) ? mem_q[idx_q] : '0;
  assign bus.result      = result_q;
  assign bus.done        = done_q;
`ifdef FEEDER_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`endif
endmodule

// File: tb/tb_neuron_feeder.sv
// tb/tb_neuron_feeder.sv - directed scoreboard bench for neuron_feeder
module tb_neuron_feeder;
  localparam int NI = 4;
  localparam int DW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_feeder_if #(.NUM_INPUTS(NI), .DATAWIDTH(DW)) bus ();

  neuron_feeder #(.NUM_INPUTS(NI), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mem_m [NI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every streamed word is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (bus.input_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_word", {16'h0, bus.input_val}, 32'hDEAD_0000);
      else chk("stream_word", {16'h0, bus.input_val}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[1:0];
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    mem_m[a]    = d;
  endtask

  task automatic push_expected();
    for (int i = 0; i < NI; i++) exp_q.push_back(mem_m[i]);
  endtask

  task automatic check_wait(input string tag);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_valid_low"}, {31'h0, bus.input_valid}, 0);
    chk({tag, "_val_zero"}, {16'h0, bus.input_val}, 0);
    chk({tag, "_busy"}, {31'h0, bus.busy}, 1);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0;
    bus.neuron_out = '0; bus.neuron_out_valid = 0;
    for (int i = 0; i < NI; i++) mem_m[i] = '0;

    // Reset state
    #1;
    chk("rst_busy", {31'h0, bus.busy}, 0);
    chk("rst_valid", {31'h0, bus.input_valid}, 0);
    chk("rst_val", {16'h0, bus.input_val}, 0);
    chk("rst_result", {16'h0, bus.result}, 0);
    chk("rst_done", {31'h0, bus.done}, 0);
`ifdef FEEDER_TIMEOUT_EN
    chk("rst_timeout", {31'h0, bus.timeout}, 0);
`endif
    tick(); tick();
    rst = 1'b1;
    tick();

    // Load 3,-5,7,12 and stream
    write_word(0, 16'd3);
    write_word(1, 16'hFFFB);
    write_word(2, 16'd7);
    write_word(3, 16'd12);
    bus.start = 1'b1; push_expected();
    tick();
    bus.start = 1'b0;
    chk("t1_first_valid", {31'h0, bus.input_valid}, 1);
    chk("t1_busy", {31'h0, bus.busy}, 1);
    repeat (NI) tick();
    check_wait("t1_wait");
    repeat (3) tick();
    chk("t1_still_wait", {31'h0, bus.busy}, 1);

    // Result capture
    bus.neuron_out = 16'h0010; bus.neuron_out_valid = 1'b1;
    tick();
    bus.neuron_out_valid = 1'b0;
    chk("t2_done", {31'h0, bus.done}, 1);
    chk("t2_result", {16'h0, bus.result}, 32'h0010);
    chk("t2_busy_low", {31'h0, bus.busy}, 0);
    tick();
    chk("t2_done_once", {31'h0, bus.done}, 0);

    // Spurious neuron_out_valid in IDLE
    bus.neuron_out = 16'h5555; bus.neuron_out_valid = 1'b1;
    tick();
    bus.neuron_out_valid = 1'b0;
    chk("idle_spur_result", {16'h0, bus.result}, 32'h0010);
    chk("idle_spur_done", {31'h0, bus.done}, 0);

    // start + write during SEND are ignored
    bus.start = 1'b1; push_expected();
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 16'd99;
    tick(); tick();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    tick(); tick();
    check_wait("t3_wait");

    // Start on the done cycle: second stream starts next cycle
    bus.neuron_out = 16'hABCD; bus.neuron_out_valid = 1'b1;
    tick();
    bus.neuron_out_valid = 1'b0;
    chk("t4_done", {31'h0, bus.done}, 1);
    chk("t4_result", {16'h0, bus.result}, 32'hABCD);
    bus.start = 1'b1; push_expected();
    tick();
    bus.start = 1'b0;
    chk("t4_b2b_valid", {31'h0, bus.input_valid}, 1);
    chk("t4_b2b_done_low", {31'h0, bus.done}, 0);
    tick();

    // Reset after two words
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", {31'h0, bus.input_valid}, 0);
    chk("t5_rst_val", {16'h0, bus.input_val}, 0);
    chk("t5_rst_busy", {31'h0, bus.busy}, 0);
    chk("t5_rst_result", {16'h0, bus.result}, 0);
    exp_q.delete();
    for (int i = 0; i < NI; i++) mem_m[i] = '0;
    tick();
    chk("t5_rst_no_done", {31'h0, bus.done}, 0);
    rst = 1'b1;
    tick();
    chk("t5_post_no_done", {31'h0, bus.done}, 0);

    // Coincident write and start; remaining buffer is cleared
    bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 16'h8001; bus.start = 1'b1;
    mem_m[0] = 16'h8001; push_expected();
    tick();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    repeat (NI) tick();
    check_wait("t6_wait");
    bus.neuron_out = 16'hFFFF; bus.neuron_out_valid = 1'b1;
    tick();
    bus.neuron_out_valid = 1'b0;
    chk("t6_done", {31'h0, bus.done}, 1);
    chk("t6_result", {16'h0, bus.result}, 32'hFFFF);
    tick();

`ifdef FEEDER_TIMEOUT_EN
    // No neuron_out_valid: timeout after TO WAIT cycles
    bus.start = 1'b1; push_expected();
    tick();
    bus.start = 1'b0;
    repeat (NI) tick();
    check_wait("t7_wait");
    repeat (TO - 1) tick();
    chk("t7_pre_timeout", {31'h0, bus.timeout}, 0);
    chk("t7_pre_busy", {31'h0, bus.busy}, 1);
    tick();
    chk("t7_timeout", {31'h0, bus.timeout}, 1);
    chk("t7_no_done", {31'h0, bus.done}, 0);
    chk("t7_busy_low", {31'h0, bus.busy}, 0);
    chk("t7_result_kept", {16'h0, bus.result}, 32'hFFFF);
    tick();
    chk("t7_timeout_once", {31'h0, bus.timeout}, 0);
`endif

    tick();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_feeder.md
NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of words streamed per transaction (>=1).
REQ-002 SHALL have parameter DATAWIDTH, default 16, width of data words.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT-state limit (used only under FEEDER_TIMEOUT_EN).
REQ-004 SHALL derive localparam ADDR_WIDTH = max(1, clog2(NUM_INPUTS)).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port wr_en  input  1  buffer write strobe.
REQ-008 SHALL have port wr_addr  input  ADDR_WIDTH  buffer write index.
REQ-009 SHALL have port wr_data  input  DATAWIDTH  buffer write data.
REQ-010 SHALL have port start  input  1  begin-transaction request.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port input_val  output  DATAWIDTH  word driven to the neuron.
REQ-013 SHALL have port input_valid  output  1  qualifies input_val.
REQ-014 SHALL have port neuron_out  input  DATAWIDTH  neuron result.
REQ-015 SHALL have port neuron_out_valid  input  1  qualifies neuron_out.
REQ-016 SHALL have port result  output  DATAWIDTH  captured neuron result.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port timeout  output  1  one-cycle abort pulse; present only under FEEDER_TIMEOUT_EN.

Function
REQ-019 SHALL hold NUM_INPUTS x DATAWIDTH register buffer; write on wr_en in IDLE when wr_addr < NUM_INPUTS; writes otherwise ignored.
REQ-020 SHALL implement FSM IDLE -> SEND -> WAIT -> IDLE; start sampled only in IDLE, ignored elsewhere.
REQ-021 SHALL, when start sampled at edge k, drive input_valid=1 on cycles k+1..k+NUM_INPUTS with input_val = buf[0], buf[1], ... in order, one word per cycle, no gaps.
REQ-022 SHALL, if wr_en and start coincide in IDLE, use the newly written word in that transaction.
REQ-023 SHALL enter WAIT after last word; input_valid=0 and input_val=0 whenever not in SEND.
REQ-024 SHALL, in WAIT, on neuron_out_valid=1 register neuron_out into result, pulse done for exactly one cycle (next cycle), return to IDLE.
REQ-025 SHALL ignore neuron_out_valid outside WAIT; result holds last captured value until next capture.
REQ-026 SHALL accept start in the same cycle done is high (back-to-back transactions, no dead cycle beyond the done cycle).
REQ-027 SHALL pass data unmodified (no sign extension, truncation, or arithmetic).

Reset
REQ-028 SHALL, on rst=0, immediately force FSM to IDLE, index counter to 0, input_valid=0, input_val=0, result=0, done=0, timeout=0, busy=0.
REQ-029 SHALL clear buffer contents to 0 on reset.
REQ-030 SHALL abort any in-flight transaction on reset with no done pulse.

Configuration
REQ-031 SHALL, with macro FEEDER_TIMEOUT_EN defined, count WAIT cycles; after TIMEOUT_CYCLES cycles without neuron_out_valid pulse timeout one cycle, leave result unchanged, no done, return to IDLE.
REQ-032 SHALL, without FEEDER_TIMEOUT_EN, omit the timeout port and counter and remain in WAIT indefinitely.

Verification
REQ-033 SHALL test: load 3,-5,7,12, start -> input_valid 4 consecutive cycles carrying 3,-5,7,12, then WAIT.
REQ-034 SHALL test: neuron_out_valid with neuron_out=0x0010 in WAIT -> result=0x0010, done high one cycle, busy low next.
REQ-035 SHALL test: start and wr_en asserted during SEND with wr_addr=0, data 99 -> stream unchanged, buf[0] unchanged.
REQ-036 SHALL test: rst low mid-SEND (after 2 words) -> outputs zero immediately, no done, new start streams from buf[0]=0.
REQ-037 SHALL test: start on done cycle -> second stream starts next cycle; spurious neuron_out_valid in IDLE leaves result unchanged.
REQ-038 SHALL test (FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=8): no neuron_out_valid -> timeout pulse after 8 WAIT cycles, done stays 0, busy drops.
